// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one registered n+1-bit adder among NREQ requesters.
// Optional signed-overflow output rsp_ovf is enabled by defining ADDER_ARB_OVF_EN.
module adder_arbiter #(
  parameter int n    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*n-1:0] req_a,
  input  logic [NREQ*n-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [n-1:0]      rsp_y,
  output logic              rsp_cout,
`ifdef ADDER_ARB_OVF_EN
  output logic              rsp_ovf,
`endif
  input  logic              rsp_ready
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic           slot_free;
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW:0]   scan_idx;
  logic           transfer;
  logic [n-1:0]   a_sel;
  logic [n-1:0]   b_sel;
  logic           cin_sel;
  logic [n:0]     sum;
`ifdef ADDER_ARB_OVF_EN
  logic           ovf;
`endif

  assign rsp_valid = (state == FULL);
  assign slot_free = (state == EMPTY) || rsp_ready;

  // Scan requesters starting at the round-robin pointer, wrapping at NREQ-1.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, ptr} + (IDW+1)'(k);
      if (scan_idx >= (IDW+1)'(NREQ))
        scan_idx = scan_idx - (IDW+1)'(NREQ);
      if (!grant_found && req_valid[scan_idx[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[IDW-1:0];
      end
    end
  end

  assign transfer  = rst_n && slot_free && grant_found;
  assign req_ready = transfer ? (NREQ'(1) << grant_idx) : '0;

  assign a_sel   = req_a[grant_idx*n +: n];
  assign b_sel   = req_b[grant_idx*n +: n];
  assign cin_sel = req_cin[grant_idx];
  assign sum     = {1'b0, a_sel} + {1'b0, b_sel} + {{n{1'b0}}, cin_sel};
`ifdef ADDER_ARB_OVF_EN
  assign ovf     = (a_sel[n-1] == b_sel[n-1]) && (sum[n-1] != a_sel[n-1]);
`endif

  // Output stage: reload on a transfer, drain to EMPTY when consumed without a new grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      ptr      <= '0;
      rsp_id   <= '0;
      rsp_y    <= '0;
      rsp_cout <= 1'b0;
`ifdef ADDER_ARB_OVF_EN
      rsp_ovf  <= 1'b0;
`endif
    end else if (slot_free) begin
      if (transfer) begin
        state    <= FULL;
        rsp_id   <= grant_idx;
        rsp_y    <= sum[n-1:0];
        rsp_cout <= sum[n];
`ifdef ADDER_ARB_OVF_EN
        rsp_ovf  <= ovf;
`endif
        ptr      <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
      end else begin
        state <= EMPTY;
      end
    end
  end

endmodule
